// File: rtl/ahb_burst_req_gen.sv
// ahb_burst_req_gen: turns one burst command into a beat-by-beat stream of
// address-phase controls for top_ahb, with write data following one cycle behind
// each accepted address beat. Illegal commands are rejected with an err pulse.
module ahb_burst_req_gen #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              hresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [2:0]        cmd_burst,
   input  logic [3:0]        cmd_len,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_sel,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   input  logic              beat_ready,
   output logic              enable,
   output logic [ADDR_W-1:0] in_haddr,
   output logic [DATA_W-1:0] in_hwdata,
   output logic [2:0]        in_hsize,
   output logic [2:0]        in_hburst,
   output logic [1:0]        in_hsel,
   output logic              in_hwrite,
   output logic [1:0]        in_htrans,
   output logic              done,
   output logic              err
);

   localparam int MAX_SIZE = $clog2(DATA_W / 8);

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   // S_CHECK is the one-cycle rejection state that carries the err pulse
   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_BEAT,
      S_DATA
   } state_t;

   state_t state, state_next;

   logic [4:0]        cmd_beats;
   logic [11:0]       cmd_bytes;
   logic [ADDR_W-1:0] cmd_step;
   logic              cmd_illegal;

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] mask_q;
   logic [4:0]        left_q;
   logic              first_q;
   logic [DATA_W-1:0] hwdata_q;
   logic [2:0]        size_q;
   logic [2:0]        burst_q;
   logic [1:0]        sel_q;
   logic              write_q;

   logic [ADDR_W-1:0] beat_step;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] addr_next;
   logic              is_wrap;

   logic              accept;
   logic              issue;
   logic              data_ok;

   // Decode the offered command: beat count, total bytes and legality
   always_comb begin
      case (cmd_burst)
         3'd0:       cmd_beats = 5'd1;
         3'd1:       cmd_beats = {1'b0, cmd_len} + 5'd1;
         3'd2, 3'd3: cmd_beats = 5'd4;
         3'd4, 3'd5: cmd_beats = 5'd8;
         default:    cmd_beats = 5'd16;
      endcase
      cmd_bytes   = 12'(cmd_beats) << cmd_size;
      cmd_step    = ADDR_W'(1) << cmd_size;
      // Odd HBURST codes are the incrementing kinds; they must stay inside one 1KB page
      cmd_illegal = (cmd_size > 3'(MAX_SIZE))
                 || ((cmd_addr & (cmd_step - ADDR_W'(1))) != '0)
                 || (cmd_burst[0] && (({2'b00, cmd_addr[9:0]} + cmd_bytes) > 12'd1024));
   end

   // Address of the following beat; wrapping bursts stay inside their aligned window
   always_comb begin
      beat_step = ADDR_W'(1) << size_q;
      addr_inc  = addr_q + beat_step;
      is_wrap   = (burst_q != 3'd0) && !burst_q[0];
      addr_next = is_wrap ? ((addr_q & ~mask_q) | (addr_inc & mask_q)) : addr_inc;
   end

   // State register
   always_ff @(posedge clk or negedge hresetn) begin
      if (!hresetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and all handshake/bus-control outputs
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      issue       = 1'b0;
      data_ok     = 1'b0;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      enable      = 1'b0;
      in_htrans   = HT_IDLE;
      done        = 1'b0;
      err         = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = hresetn;
            accept    = cmd_valid && hresetn;
            if (accept) begin
               state_next = cmd_illegal ? S_CHECK : S_BEAT;
            end
         end
         S_CHECK: begin
            err        = 1'b1;
            state_next = S_IDLE;
         end
         S_BEAT: begin
            enable  = 1'b1;
            data_ok = !write_q || wdata_valid;
            if (data_ok) begin
               in_htrans = first_q ? HT_NONSEQ : HT_SEQ;
            end else begin
               in_htrans = first_q ? HT_IDLE : HT_BUSY;
            end
            if (beat_ready && data_ok) begin
               issue       = 1'b1;
               wdata_ready = write_q;
               if (left_q == 5'd1) begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            enable = 1'b1;
            if (beat_ready) begin
               done       = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Burst datapath: attribute latches, beat address/counter and write data register
   always_ff @(posedge clk or negedge hresetn) begin
      if (!hresetn) begin
         addr_q   <= '0;
         mask_q   <= '0;
         left_q   <= '0;
         first_q  <= 1'b0;
         hwdata_q <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         sel_q    <= '0;
         write_q  <= 1'b0;
      end else begin
         if (accept) begin
            size_q  <= cmd_size;
            burst_q <= cmd_burst;
            sel_q   <= cmd_sel;
            write_q <= cmd_write;
            if (!cmd_illegal) begin
               addr_q  <= cmd_addr;
               mask_q  <= ADDR_W'(cmd_bytes) - ADDR_W'(1);
               left_q  <= cmd_beats;
               first_q <= 1'b1;
            end
         end
         if (issue) begin
            addr_q  <= addr_next;
            left_q  <= left_q - 5'd1;
            first_q <= 1'b0;
         end
         if (wdata_ready) begin
            hwdata_q <= wdata;
         end
      end
   end

   assign in_haddr  = addr_q;
   assign in_hwdata = hwdata_q;
   assign in_hsize  = size_q;
   assign in_hburst = burst_q;
   assign in_hsel   = sel_q;
   assign in_hwrite = write_q;

endmodule

// File: tb/tb_ahb_burst_req_gen.sv
// tb_ahb_burst_req_gen: directed bursts against a scoreboard that derives every
// expected beat address and data word from the burst rules with plain arithmetic.
module tb_ahb_burst_req_gen;

   logic        clk = 1'b0;
   logic        hresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [2:0]  cmd_burst;
   logic [3:0]  cmd_len;
   logic        cmd_write;
   logic [1:0]  cmd_sel;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [31:0] wdata;
   logic        beat_ready;
   logic        enable;
   logic [31:0] in_haddr;
   logic [31:0] in_hwdata;
   logic [2:0]  in_hsize;
   logic [2:0]  in_hburst;
   logic [1:0]  in_hsel;
   logic        in_hwrite;
   logic [1:0]  in_htrans;
   logic        done;
   logic        err;

   ahb_burst_req_gen #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .hresetn(hresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
      .cmd_write(cmd_write), .cmd_sel(cmd_sel),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .beat_ready(beat_ready), .enable(enable), .in_haddr(in_haddr),
      .in_hwdata(in_hwdata), .in_hsize(in_hsize), .in_hburst(in_hburst),
      .in_hsel(in_hsel), .in_hwrite(in_hwrite), .in_htrans(in_htrans),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [31:0] hwdata;
      logic        br, dn, er, crdy, wrdy, en, acc;
   } cyc_t;
   cyc_t tr[$];

   // Scoreboard expectations
   logic [31:0] exp_addr[$];
   bit          exp_first[$];
   logic [31:0] exp_data[$];
   bit          data_pending = 0;
   logic [31:0] data_exp;
   logic [2:0]  exp_size, exp_burst;
   logic [1:0]  exp_sel;
   logic        exp_write;
   bit          sb_on = 0;

   // Write-data and bus-ready drivers
   logic [31:0] wq[$];
   int stall_after, stall_len, stall_left, ncons;
   int br_after, br_len, br_left, nbeats;
   int acc;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s", name);
   endtask

   // Scoreboard: compares every accepted beat and its data phase with the model
   always @(negedge clk) begin
      if (sb_on && hresetn) begin
         if (data_pending) begin
            checkOutput("sb_hwdata", in_hwdata, data_exp);
            data_pending = 0;
         end
         if (enable) begin
            checkOutput("sb_hsize", in_hsize, exp_size);
            checkOutput("sb_hburst", in_hburst, exp_burst);
            checkOutput("sb_hsel", in_hsel, exp_sel);
            checkOutput("sb_hwrite", in_hwrite, exp_write);
            if (!exp_write) checkOutput("sb_rd_wready", wdata_ready, 0);
         end else begin
            checkOutput("sb_idle_htrans", in_htrans, 2'b00);
         end
         if (in_htrans[1] && beat_ready) begin
            if (exp_addr.size() == 0) begin
               failNow($sformatf("sb_extra_beat: haddr 0x%0h not expected", in_haddr));
            end else begin
               checkOutput("sb_haddr", in_haddr, exp_addr.pop_front());
               checkOutput("sb_htrans", in_htrans, exp_first.pop_front() ? 2'b10 : 2'b11);
               if (exp_write) begin
                  data_exp     = exp_data.pop_front();
                  data_pending = 1;
               end
            end
         end
         if (done || err) begin
            checkOutput("sb_done_err_excl", done && err, 0);
            checkOutput("sb_pulse_vs_ready", cmd_ready, 0);
         end
      end
   end

   // One clock: sample at negedge, then update driven inputs just after posedge
   task automatic step();
      cyc_t c;
      bit   cons, bacc;
      @(negedge clk);
      c.addr = in_haddr;   c.trans = in_htrans; c.hwdata = in_hwdata;
      c.br   = beat_ready; c.dn    = done;      c.er     = err;
      c.crdy = cmd_ready;  c.wrdy  = wdata_ready; c.en   = enable;
      c.acc  = cmd_valid && cmd_ready;
      tr.push_back(c);
      cons = wdata_valid && wdata_ready;
      bacc = in_htrans[1] && beat_ready;
      @(posedge clk);
      #1;
      if (c.acc) cmd_valid = 1'b0;
      if (cons) begin
         void'(wq.pop_front());
         ncons++;
         if (ncons == stall_after) stall_left = stall_len;
      end else if (stall_left > 0) begin
         stall_left--;
      end
      if (bacc) begin
         nbeats++;
         if (nbeats == br_after) br_left = br_len;
      end else if (br_left > 0) begin
         br_left--;
      end
      wdata_valid = (wq.size() > 0) && (stall_left == 0);
      wdata       = (wq.size() > 0) ? wq[0] : 32'h0;
      beat_ready  = (br_left == 0);
   endtask

   // Offer a command and load the scoreboard from the burst rules
   task automatic startCmd(input logic [31:0] a, input int size, input int burst,
                           input int len, input bit wr, input logic [1:0] sel);
      int  nb, stp, win, base;
      bit  legal, wrap;
      nb    = (burst == 0) ? 1 : (burst == 1) ? len + 1 : (burst <= 3) ? 4 : (burst <= 5) ? 8 : 16;
      stp   = 1 << size;
      legal = (size <= 2) && ((a % stp) == 0)
           && !((burst % 2 == 1) && ((a % 1024) + nb * stp > 1024));
      wrap  = (burst != 0) && (burst % 2 == 0);
      win   = nb * stp;
      base  = int'(a) - (int'(a) % win);
      tr.delete();
      nbeats = 0; ncons = 0; br_left = 0; beat_ready = 1'b1;
      exp_size = 3'(size); exp_burst = 3'(burst); exp_sel = sel; exp_write = wr;
      if (legal) begin
         for (int k = 0; k < nb; k++) begin
            if (wrap) exp_addr.push_back(32'(base + (int'(a) - base + k * stp) % win));
            else      exp_addr.push_back(a + 32'(k * stp));
            exp_first.push_back(k == 0);
         end
         if (wr) foreach (wq[i]) exp_data.push_back(wq[i]);
      end
      cmd_addr = a; cmd_size = 3'(size); cmd_burst = 3'(burst); cmd_len = 4'(len);
      cmd_write = wr; cmd_sel = sel; cmd_valid = 1'b1;
      wdata_valid = (wq.size() > 0) && (stall_left == 0);
      wdata       = (wq.size() > 0) ? wq[0] : 32'h0;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input int size, input int burst,
                                input int len, input bit wr, input logic [1:0] sel,
                                output int acc_idx);
      bit fin = 0;
      startCmd(a, size, burst, len, wr, sel);
      for (int i = 0; i < 300 && !fin; i++) begin
         step();
         if (tr[tr.size()-1].dn || tr[tr.size()-1].er) fin = 1;
      end
      if (!fin) failNow("burst_timeout: no done or err within 300 cycles");
      step();
      step();
      checkOutput("sb_drain", exp_addr.size(), 0);
      acc_idx = -1;
      foreach (tr[i]) if (tr[i].acc && acc_idx < 0) acc_idx = i;
      if (acc_idx < 0) begin
         failNow("cmd_accept: command never accepted");
         acc_idx = 0;
      end
      stall_after = -1; stall_len = 0; stall_left = 0;
      br_after = -1; br_len = 0; br_left = 0;
      wq.delete();
   endtask

   function automatic int countDone();
      int n = 0;
      foreach (tr[i]) n += int'(tr[i].dn);
      return n;
   endfunction

   function automatic int countErr();
      int n = 0;
      foreach (tr[i]) n += int'(tr[i].er);
      return n;
   endfunction

   function automatic int countTrans(input logic [1:0] t);
      int n = 0;
      foreach (tr[i]) n += (tr[i].trans == t) ? 1 : 0;
      return n;
   endfunction

   // Watchdog so the run can never hang
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] e_addr[4];
      logic [1:0]  e_tr[4];
      int b;
      hresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_burst = '0;
      cmd_len = '0; cmd_write = 1'b0; cmd_sel = '0; wdata_valid = 1'b0; wdata = '0;
      beat_ready = 1'b1;
      stall_after = -1; stall_len = 0; stall_left = 0; ncons = 0;
      br_after = -1; br_len = 0; br_left = 0; nbeats = 0;

      // Reset values
      #12;
      checkOutput("rst_cmd_ready", cmd_ready, 0);
      checkOutput("rst_enable", enable, 0);
      checkOutput("rst_htrans", in_htrans, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_haddr", in_haddr, 0);
      checkOutput("rst_hwdata", in_hwdata, 0);
      @(posedge clk); #1 hresetn = 1'b1;
      @(negedge clk);
      checkOutput("rst_release_ready", cmd_ready, 1);
      @(posedge clk); #1;
      sb_on = 1;

      // INCR4 write 0x100: beats at T+1..T+4, data one cycle later, done in DATA (T+5),
      // the sixth cycle counting the accept cycle
      wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      applyStimulus(32'h100, 2, 3, 0, 1'b1, 2'b01, acc);
      e_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
      e_tr   = '{2'b10, 2'b11, 2'b11, 2'b11};
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("incr4_haddr%0d", k), tr[acc+1+k].addr, e_addr[k]);
         checkOutput($sformatf("incr4_htrans%0d", k), tr[acc+1+k].trans, e_tr[k]);
         checkOutput($sformatf("incr4_hwdata%0d", k), tr[acc+2+k].hwdata, 32'hA0 + 32'(k));
      end
      checkOutput("incr4_done_at_data", tr[acc+5].dn, 1);
      checkOutput("incr4_done_count", countDone(), 1);

      // WRAP4 read 0x38
      applyStimulus(32'h38, 2, 2, 0, 1'b0, 2'b10, acc);
      e_addr = '{32'h38, 32'h3C, 32'h30, 32'h34};
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("wrap4_haddr%0d", k), tr[acc+1+k].addr, e_addr[k]);
      b = 0;
      foreach (tr[i]) b += int'(tr[i].wrdy);
      checkOutput("wrap4_no_wready", b, 0);
      checkOutput("wrap4_done_count", countDone(), 1);

      // INCR16 crossing 1KB, then illegal size, then misaligned address
      applyStimulus(32'h3F0, 2, 7, 0, 1'b0, 2'b00, acc);
      checkOutput("incr16_cross_err", tr[acc+1].er, 1);
      checkOutput("incr16_cross_enable", tr[acc+1].en, 0);
      checkOutput("incr16_cross_no_nonseq", countTrans(2'b10), 0);
      checkOutput("incr16_cross_ready_back", tr[acc+2].crdy, 1);
      applyStimulus(32'h3F0, 3, 7, 0, 1'b0, 2'b00, acc);
      checkOutput("size3_err", tr[acc+1].er, 1);
      checkOutput("size3_no_nonseq", countTrans(2'b10), 0);
      applyStimulus(32'h102, 2, 3, 0, 1'b0, 2'b00, acc);
      checkOutput("misaligned_err", tr[acc+1].er, 1);
      checkOutput("misaligned_err_count", countErr(), 1);

      // INCR boundary: 3 halfwords ending exactly at 0x3FF are legal, 4 cross
      applyStimulus(32'h3FA, 1, 1, 2, 1'b0, 2'b11, acc);
      checkOutput("incr_edge_last_addr", tr[acc+3].addr, 32'h3FE);
      checkOutput("incr_edge_done", countDone(), 1);
      applyStimulus(32'h3FA, 1, 1, 3, 1'b0, 2'b11, acc);
      checkOutput("incr_cross_err", tr[acc+1].er, 1);

      // WRAP8 halfword read from 0x0E wraps to 0x00 on the second beat
      applyStimulus(32'h0E, 1, 4, 0, 1'b0, 2'b01, acc);
      checkOutput("wrap8_first", tr[acc+1].addr, 32'h0E);
      checkOutput("wrap8_wrap", tr[acc+2].addr, 32'h00);
      checkOutput("wrap8_last", tr[acc+8].addr, 32'h0C);

      // INCR8 write with write data missing for 2 cycles before beat 3
      for (int k = 0; k < 8; k++) wq.push_back(32'hB000_0000 + 32'(k));
      stall_after = 2; stall_len = 2;
      applyStimulus(32'h200, 2, 5, 0, 1'b1, 2'b10, acc);
      checkOutput("incr8_busy_count", countTrans(2'b01), 2);
      b = -1;
      foreach (tr[i]) if (tr[i].trans == 2'b01 && b < 0) b = i;
      if (b < 0) begin
         failNow("incr8_busy: no BUSY cycle seen");
      end else begin
         checkOutput("incr8_busy0_addr", tr[b].addr, 32'h208);
         checkOutput("incr8_busy1_trans", tr[b+1].trans, 2'b01);
         checkOutput("incr8_busy1_addr", tr[b+1].addr, 32'h208);
         checkOutput("incr8_resume_trans", tr[b+2].trans, 2'b11);
         checkOutput("incr8_resume_addr", tr[b+2].addr, 32'h208);
      end
      checkOutput("incr8_done_count", countDone(), 1);

      // INCR4 read with bus wait states on beat 2
      br_after = 1; br_len = 3;
      applyStimulus(32'h40, 2, 3, 0, 1'b0, 2'b00, acc);
      b = 0;
      foreach (tr[i]) if (!tr[i].br && tr[i].trans == 2'b11 && tr[i].addr == 32'h44) b++;
      checkOutput("wait_frozen_cycles", b, 3);
      checkOutput("wait_beat2_accept", tr[acc+5].addr, 32'h44);
      checkOutput("wait_done_count", countDone(), 1);

      // SINGLE write whose data arrives late: first beat held off as IDLE
      wq.push_back(32'hC0FFEE01);
      stall_left = 3;
      applyStimulus(32'h10, 2, 0, 0, 1'b1, 2'b01, acc);
      checkOutput("single_holdoff_trans", tr[acc+1].trans, 2'b00);
      checkOutput("single_holdoff_enable", tr[acc+1].en, 1);
      checkOutput("single_nonseq", tr[acc+3].trans, 2'b10);
      checkOutput("single_data", tr[acc+4].hwdata, 32'hC0FFEE01);

      // Asynchronous reset in the middle of an INCR8 write
      for (int k = 0; k < 8; k++) wq.push_back(32'hD000_0000 + 32'(k));
      startCmd(32'h300, 2, 5, 0, 1'b1, 2'b01);
      for (int i = 0; i < 60 && nbeats < 4; i++) step();
      checkOutput("rst_mid_beats", nbeats, 4);
      #2;
      hresetn = 1'b0; cmd_valid = 1'b0; wq.delete(); wdata_valid = 1'b0;
      #1;
      checkOutput("rst_mid_htrans", in_htrans, 2'b00);
      checkOutput("rst_mid_enable", enable, 0);
      checkOutput("rst_mid_done", done, 0);
      checkOutput("rst_mid_ready", cmd_ready, 0);
      exp_addr.delete(); exp_first.delete(); exp_data.delete(); data_pending = 0;
      @(posedge clk); @(posedge clk); #3 hresetn = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_release_ready", cmd_ready, 1);
      checkOutput("rst_mid_release_enable", enable, 0);
      @(posedge clk); #1;
      applyStimulus(32'h80, 2, 0, 0, 1'b0, 2'b00, acc);
      checkOutput("post_rst_nonseq", tr[acc+1].trans, 2'b10);
      checkOutput("post_rst_addr", tr[acc+1].addr, 32'h80);
      checkOutput("post_rst_done", countDone(), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
